// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the M-extension execution unit.
//   - funct3 encodings of the eight M-ops
//   - FSM state enum
//   - helper deciding whether a divide resolves without iterating
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

  // A divide is special when the divisor is zero, or for the signed ops
  // (funct3[0]=0) when the operands are the most-negative / minus-one pair.
  function automatic logic div_is_special(input logic [2:0] f3,
                                          input logic       divisor_zero,
                                          input logic       ovf_pattern);
    return f3[2] && (divisor_zero || (ovf_pattern && !f3[0]));
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: iterative unsigned radix-2 restoring divider.
//   clk, rst           clock, asynchronous active-high reset
//   start              load operands and begin XLEN iterations
//   clear              abandon the current division
//   dividend, divisor  unsigned operands (sampled on start)
//   done               high during the cycle that computes the last bit
//   quotient,remainder results, valid the cycle after done
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            clear,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt_reg;
  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] dvs_reg;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Partial remainder is always below the divisor, so the shifted value fits
  // in XLEN+1 bits and diff's top bit is a clean "went negative" flag.
  assign shifted = {rem_reg, quo_reg[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_reg};

  // Asserted during the final iteration so the caller can move on at the
  // same edge the last quotient bit is written.
  assign done      = (cnt_reg == CW'(1));
  assign quotient  = quo_reg;
  assign remainder = rem_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      quo_reg <= '0;
      rem_reg <= '0;
      dvs_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= CW'(XLEN);
      quo_reg <= dividend;
      rem_reg <= '0;
      dvs_reg <= divisor;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CW'(1);
      if (!diff[XLEN]) begin
        rem_reg <= diff[XLEN-1:0];
        quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
      end else begin
        rem_reg <= shifted[XLEN-1:0];
        quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: multi-cycle RV32M/RV64M multiply/divide unit (EXE stage).
//   clk, rst            clock, asynchronous active-high reset
//   flush               squash any in-flight or held op
//   in_valid/in_ready   request handshake (in_ready = state IDLE)
//   funct3, rs1, rs2    op select and operands
//   in_tag              destination tag carried with the op
//   out_valid/out_ready result handshake
//   out_result, out_tag registered result and its tag
//   busy                op in flight or result held
module exe_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  // The product is registered at the accept edge, so MUL only has to wait
  // MUL_LAT-1 further edges: the counter starts one below MUL_LAT-1.
  localparam int CNT_LOAD = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  state_t state_reg, state_next;

  logic             accept;
  logic             sa, sb;
  logic [2*XLEN-1:0] a_w, b_w, prod;
  logic [XLEN-1:0]  mul_res;
  logic             b_zero, ovf_pattern, special;
  logic [XLEN-1:0]  spec_res;
  logic             div_signed, a_neg, b_neg;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic             div_start, div_done;
  logic [XLEN-1:0]  div_q, div_r, fix_res;

  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0]  prod_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             rem_op_reg, neg_q_reg, neg_r_reg;
  logic [XLEN-1:0]  out_result_reg, result_next;
  logic [TAG_W-1:0] out_tag_reg, tag_next;
  logic             out_valid_reg;

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign accept   = in_valid && in_ready && !flush;

  // Multiply: sign/zero-extend to 2*XLEN and keep the product modulo 2^(2*XLEN).
  assign sa      = (funct3 != F3_MULHU);
  assign sb      = (funct3 == F3_MUL) || (funct3 == F3_MULH);
  assign a_w     = {{XLEN{sa & rs1[XLEN-1]}}, rs1};
  assign b_w     = {{XLEN{sb & rs2[XLEN-1]}}, rs2};
  assign prod    = a_w * b_w;
  assign mul_res = (funct3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Special divides resolve directly from the operands.
  assign b_zero      = (rs2 == '0);
  assign ovf_pattern = (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);
  assign special     = div_is_special(funct3, b_zero, ovf_pattern);
  assign spec_res    = b_zero ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : rs1);

  assign div_signed = !funct3[0];
  assign a_neg      = div_signed & rs1[XLEN-1];
  assign b_neg      = div_signed & rs2[XLEN-1];
  assign mag_a      = a_neg ? -rs1 : rs1;
  assign mag_b      = b_neg ? -rs2 : rs2;
  assign div_start  = accept && funct3[2] && !special;

  muldiv_div_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .clear     (flush),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign fix_res = rem_op_reg ? (neg_r_reg ? -div_r : div_r)
                              : (neg_q_reg ? -div_q : div_q);

  always_comb begin
    state_next  = state_reg;
    result_next = out_result_reg;
    tag_next    = out_tag_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (!funct3[2]) begin
            state_next = (MUL_LAT == 1) ? DONE : MUL;
          end else begin
            state_next = special ? DONE : DIV;
          end
          result_next = funct3[2] ? spec_res : mul_res;
          tag_next    = in_tag;
        end
      end
      MUL: begin
        if (cnt_reg == '0) begin
          state_next  = DONE;
          result_next = prod_reg;
          tag_next    = tag_reg;
        end
      end
      DIV: begin
        if (div_done) state_next = FIX;
      end
      FIX: begin
        state_next  = DONE;
        result_next = fix_res;
        tag_next    = tag_reg;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next  = IDLE;
      result_next = out_result_reg;
      tag_next    = out_tag_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      prod_reg       <= '0;
      tag_reg        <= '0;
      rem_op_reg     <= 1'b0;
      neg_q_reg      <= 1'b0;
      neg_r_reg      <= 1'b0;
      out_result_reg <= '0;
      out_tag_reg    <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= (state_next == DONE);
      // Result/tag only change on entry to DONE, so they are held while stalled.
      if (state_reg != DONE && state_next == DONE) begin
        out_result_reg <= result_next;
        out_tag_reg    <= tag_next;
      end
      if (accept) begin
        cnt_reg    <= CNT_W'(CNT_LOAD);
        prod_reg   <= mul_res;
        tag_reg    <= in_tag;
        rem_op_reg <= funct3[1];
        neg_q_reg  <= a_neg ^ b_neg;
        neg_r_reg  <= a_neg;
      end else if (state_reg == MUL && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign out_tag    = out_tag_reg;

endmodule
